// File: rtl/inst_loader_if.sv
// Loader-facing bundle: session control, byte stream in, instruction-memory write out.
interface inst_loader_if #(
  parameter int INST_W = 26,
  parameter int ADDR_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0]       word_count;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [INST_W-1:0] mem_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [15:0]       words_written;

  modport master (
    output start, base_addr, word_count, in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_data, busy, done, err, words_written
  );

  modport slave (
    input  start, base_addr, word_count, in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_data, busy, done, err, words_written
  );
endinterface

// File: rtl/inst_loader.sv
// Packs big-endian byte groups into instruction words written from a base address.
// The write strobe comes one cycle after the 4th byte; in_ready drops during WRITE, so the peak rate is 5 cycles per word.
module inst_loader #(
  parameter int INST_W = 26,
  parameter int ADDR_W = 16
) (
  input logic         clk,
  input logic         rst,
  inst_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] base;
  logic [15:0]       count;
  logic [15:0]       word_idx;
  logic [15:0]       word_idx_inc;
  logic [1:0]        byte_idx;
  logic [23:0]       asm_q;
  logic [31:0]       asm_nxt;
  logic              accept;
  logic              last_byte;
  logic              word_ok;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [INST_W-1:0] mem_data_q;
  logic              err_q;
  logic [15:0]       words_written_q;

  // Only the first three bytes are stored; the 4th completes the word on the fly.
  assign accept       = (state == RECV) && bus.in_valid;
  assign last_byte    = accept && (byte_idx == 2'd3);
  assign asm_nxt      = {asm_q, bus.in_data};
  assign word_ok      = (asm_nxt[31:INST_W] == '0);
  assign word_idx_inc = word_idx + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nxt = (bus.word_count == 16'd0) ? DONE : RECV;
      end
      RECV: begin
        bus.in_ready = 1'b1;
        if (last_byte) state_nxt = WRITE;
      end
      WRITE: state_nxt = (word_idx_inc == count) ? DONE : RECV;
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base            <= '0;
      count           <= '0;
      word_idx        <= '0;
      byte_idx        <= '0;
      asm_q           <= '0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_data_q      <= '0;
      err_q           <= 1'b0;
      words_written_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            base            <= bus.base_addr;
            count           <= bus.word_count;
            word_idx        <= '0;
            byte_idx        <= '0;
            err_q           <= 1'b0;
            words_written_q <= '0;
          end
        end
        RECV: begin
          if (accept) begin
            asm_q    <= asm_nxt[23:0];
            byte_idx <= byte_idx + 2'd1;
          end
          // Address and data only move for a good word so they hold while mem_we is low.
          if (last_byte && word_ok) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= base + word_idx[ADDR_W-1:0];
            mem_data_q <= asm_nxt[INST_W-1:0];
          end
        end
        WRITE: begin
          word_idx <= word_idx_inc;
          byte_idx <= '0;
          if (mem_we_q) words_written_q <= words_written_q + 16'd1;
          else          err_q           <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_data      = mem_data_q;
  assign bus.err           = err_q;
  assign bus.words_written = words_written_q;

endmodule
